multi_rate_divider: RTL and testbench

Parametrised successor to the single 1 Hz enable divider. It turns the system clock into one common base tick, then divides that tick down into NUM_CH independent enable strobes, each with a runtime-programmable ratio. Each channel also drives a 50 % duty toggle output for lamp blinking. It feeds the traffic-light FSM and its phase timers with per-channel single-cycle enables.

---
 rtl/multi_rate_divider.sv | 120 ++++++++++++
 tb/tb_multi_rate_divider.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_rate_divider.sv
// Base-tick prescaler + NUM_CH programmable enable dividers; toggle outputs built only with MULTI_RATE_DIVIDER_TOGGLE_EN.
// Latency: base_tick registered; ch_en one cycle after the base_tick it counts; all outputs registered.
// Backpressure: none; run=0 freezes counting, sync_clear restarts it, div_load reprograms a channel.
module multi_rate_divider #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BASE_HZ     = 1000,
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 1000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic                    sync_clear,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  output logic                    base_tick,
  output logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       ch_toggle
);

  localparam int                PRESCALE = CLK_FREQ_HZ / BASE_HZ;
  localparam int                PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0]     P_LAST   = PW'(PRESCALE - 1);
  localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(DEFAULT_DIV);

  logic [PW-1:0] p_q, p_d;
  logic          tick_q, tick_d;

  always_comb begin
    p_d    = p_q;
    tick_d = 1'b0;
    if (sync_clear) begin
      p_d = '0;
    end else if (run) begin
      if (p_q == P_LAST) begin
        p_d    = '0;
        tick_d = 1'b1;
      end else begin
        p_d = p_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_q    <= '0;
      tick_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      tick_q <= tick_d;
    end
  end

  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [DIV_W-1:0]  div_d [NUM_CH];
  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;

  // A load (or clear) in the same cycle as a tick discards that tick for the channel.
  always_comb begin
    en_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      div_d[k] = div_q[k];
      cnt_d[k] = cnt_q[k];
      if (div_load[k]) begin
        div_d[k] = div_val[k*DIV_W +: DIV_W];
      end
      if (sync_clear || div_load[k]) begin
        cnt_d[k] = '0;
      end else if (run && tick_q && (div_q[k] != '0)) begin
        if (cnt_q[k] == div_q[k] - DIV_W'(1)) begin
          cnt_d[k] = '0;
          en_d[k]  = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        div_q[k] <= DIV_RST;
        cnt_q[k] <= '0;
      end
      en_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

`ifdef MULTI_RATE_DIVIDER_TOGGLE_EN
  logic [NUM_CH-1:0] tog_q, tog_d;

  always_comb begin
    tog_d = sync_clear ? '0 : (tog_q ^ en_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tog_q <= '0;
    end else begin
      tog_q <= tog_d;
    end
  end

  assign ch_toggle = tog_q;
`else
  assign ch_toggle = '0;
`endif

  assign base_tick = tick_q;
  assign ch_en     = en_q;

endmodule

// File: tb/tb_multi_rate_divider.sv
// Randomised bench for multi_rate_divider: a tick-counting reference model feeds a per-cycle expectation queue.
// A negedge monitor pops and compares each cycle; async reset is checked directly.
module tb_multi_rate_divider;

  localparam int CLK_HZ = 100;
  localparam int B_HZ   = 10;
  localparam int P      = CLK_HZ / B_HZ;
  localparam int NCH    = 2;
  localparam int DW     = 8;
  localparam int DEFD   = 3;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                run;
  logic                sync_clear;
  logic [NCH*DW-1:0]   div_val;
  logic [NCH-1:0]      div_load;
  logic                base_tick;
  logic [NCH-1:0]      ch_en;
  logic [NCH-1:0]      ch_toggle;

  multi_rate_divider #(
    .CLK_FREQ_HZ(CLK_HZ), .BASE_HZ(B_HZ), .NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DEFD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .sync_clear(sync_clear),
    .div_val(div_val), .div_load(div_load),
    .base_tick(base_tick), .ch_en(ch_en), .ch_toggle(ch_toggle)
  );

  always #5 clock = ~clock;

  typedef struct {
    int       cyc;
    bit       bt;
    bit [1:0] en;
    bit [1:0] tog;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: counts run cycles and consumed ticks, decides pulses by divisibility.
  int       m_run_cnt;
  bit       m_bt;
  int       m_div [NCH];
  int       m_ticks [NCH];
  bit [1:0] m_tog;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic model_reset();
    m_run_cnt = 0;
    m_bt      = 1'b0;
    m_tog     = '0;
    for (int k = 0; k < NCH; k++) begin
      m_div[k]   = DEFD;
      m_ticks[k] = 0;
    end
  endtask

  task automatic step(input bit r, input bit c, input bit [1:0] ld, input bit [15:0] v);
    exp_t     e;
    bit [1:0] en_n;
    run        = r;
    sync_clear = c;
    div_load   = ld;
    div_val    = v;
    en_n       = '0;
    for (int k = 0; k < NCH; k++) begin
      int slice;
      slice = int'(v[k*DW +: DW]);
      if (c) begin
        m_ticks[k] = 0;
        m_tog[k]   = 1'b0;
        if (ld[k]) m_div[k] = slice;
      end else if (ld[k]) begin
        m_div[k]   = slice;
        m_ticks[k] = 0;
      end else if (r && m_bt && m_div[k] != 0) begin
        m_ticks[k]++;
        if (m_ticks[k] % m_div[k] == 0) begin
          en_n[k]  = 1'b1;
          m_tog[k] = ~m_tog[k];
        end
      end
    end
    if (c) begin
      m_run_cnt = 0;
      m_bt      = 1'b0;
    end else if (r) begin
      m_run_cnt++;
      m_bt = (m_run_cnt % P == 0);
    end else begin
      m_bt = 1'b0;
    end
    e.cyc = cyc + 1;
    e.bt  = m_bt;
    e.en  = en_n;
`ifdef MULTI_RATE_DIVIDER_TOGGLE_EN
    e.tog = m_tog;
`else
    e.tog = '0;
`endif
    q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, 16'h0);
  endtask

  task automatic run_until_tick();
    for (int i = 0; i < 2*P && !m_bt; i++) step(1'b1, 1'b0, 2'b00, 16'h0);
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      vectors++;
      if (base_tick !== 1'b0 || ch_en !== '0 || ch_toggle !== '0) begin
        miscompares++;
        $display("FAIL in_reset cyc=%0d: got bt=%b en=%b tog=%b, expected all 0",
                 cyc, base_tick, ch_en, ch_toggle);
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (e.cyc != cyc || base_tick !== e.bt || ch_en !== e.en || ch_toggle !== e.tog) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d (exp cyc %0d): got bt=%b en=%b tog=%b, expected bt=%b en=%b tog=%b",
                 cyc, e.cyc, base_tick, ch_en, ch_toggle, e.bt, e.en, e.tog);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    run        = 1'b0;
    sync_clear = 1'b0;
    div_val    = '0;
    div_load   = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;

    // Defaults: ticks every 10 cycles, both channels every 30.
    run_steps(100);

    // ch0 divides by 1, ch1 disabled.
    step(1'b1, 1'b0, 2'b11, {8'd0, 8'd1});
    run_steps(60);

    // Load ch0 exactly while a tick is visible: that tick is discarded.
    run_until_tick();
    step(1'b1, 1'b0, 2'b01, {8'd0, 8'd2});
    run_steps(45);

    // Freeze mid-period for 25 cycles.
    step(1'b1, 1'b0, 2'b11, {8'd3, 8'd2});
    run_until_tick();
    run_steps(3);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 2'b00, 16'h0);
    run_steps(70);

    // sync_clear with a concurrent load on ch1.
    run_steps(4);
    step(1'b1, 1'b1, 2'b10, {8'd2, 8'd0});
    run_steps(60);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      bit        r, c;
      bit [1:0]  ld;
      bit [15:0] v;
      r     = ($urandom_range(0, 19) != 0);
      c     = ($urandom_range(0, 199) == 0);
      ld[0] = ($urandom_range(0, 59) == 0);
      ld[1] = ($urandom_range(0, 59) == 0);
      v     = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))};
      step(r, c, ld, v);
    end

    // Asynchronous reset mid-count: outputs clear at once, divisors return to default.
    step(1'b1, 1'b0, 2'b11, {8'd1, 8'd1});
    run_until_tick();
    run_steps(4);
    q.delete();
    reset_n = 1'b0;
    #1;
    vectors++;
    if (base_tick !== 1'b0 || ch_en !== '0 || ch_toggle !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got bt=%b en=%b tog=%b, expected all 0", base_tick, ch_en, ch_toggle);
    end
    model_reset();
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b1;
    run_steps(100);

    @(negedge clock);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
